// File: rtl/iq_commit_pkg.sv
// Shared sizing, FSM encoding and helper types for the IQ commit stage.
package iq_commit_pkg;

    localparam int unsigned IQ_DEPTH = 8;
    localparam int unsigned PTR_W    = 3;
    localparam int unsigned CNT_W    = PTR_W + 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } commit_state_e;

    typedef logic [PTR_W-1:0]    iq_ptr_t;
    typedef logic [IQ_DEPTH-1:0] iq_vec_t;

endpackage

// File: rtl/iq_commit_select.sv
// Combinational commit selection for the two oldest IQ entries.
//  head_i      : oldest entry position
//  validbit_i  : occupied entries
//  finished_i  : executed entries
//  is_mem_i    : entry is a load/store
//  is_halt_i   : entry is HALT
//  state_i     : commit FSM state
//  head1_o     : head + 1 modulo depth
//  c0_o, c1_o  : oldest / second-oldest retire this cycle
//  mem_o       : a retiring entry is a memory op
//  halt_o      : a retiring entry is HALT
module iq_commit_select
    import iq_commit_pkg::*;
(
    input  iq_ptr_t       head_i,
    input  iq_vec_t       validbit_i,
    input  iq_vec_t       finished_i,
    input  iq_vec_t       is_mem_i,
    input  iq_vec_t       is_halt_i,
    input  commit_state_e state_i,
    output iq_ptr_t       head1_o,
    output logic          c0_o,
    output logic          c1_o,
    output logic          mem_o,
    output logic          halt_o
);

    always_comb begin
        head1_o = head_i + PTR_W'(1);
        c0_o    = (state_i == ST_RUN) && validbit_i[head_i] && finished_i[head_i];
        // Second slot is blocked behind a HALT and never pairs two memory ops.
        c1_o    = c0_o && !is_halt_i[head_i] &&
                  validbit_i[head1_o] && finished_i[head1_o] &&
                  !(is_mem_i[head_i] && is_mem_i[head1_o]);
        mem_o   = (c0_o && is_mem_i[head_i]) || (c1_o && is_mem_i[head1_o]);
        halt_o  = (c0_o && is_halt_i[head_i]) || (c1_o && is_halt_i[head1_o]);
    end

endmodule

// File: rtl/iq_commit.sv
// In-order commit/retire stage for the 8-entry instruction queue.
// Optional statistics counters are enabled with macro IQ_COMMIT_STATS_EN.
//  clk, nrst          : clock, async active-low reset
//  alloc_valid/is_mem/is_halt : decoded instruction offered at tail
//  alloc_ready/alloc_pos      : slot accepted / position given (tail)
//  finish             : execution finish pulses per entry
//  flush              : synchronous clear of all in-flight state
//  validbit/finished  : per-entry occupancy / executed flags
//  commit0/1_valid/pos: up to two in-order retirements per cycle
//  commit_mem         : a retiring entry is a memory op
//  halted             : HALT has committed
//  stat_retired, stat_full_stalls : saturating counters (IQ_COMMIT_STATS_EN)
module iq_commit
    import iq_commit_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             alloc_valid,
    input  logic             alloc_is_mem,
    input  logic             alloc_is_halt,
    output logic             alloc_ready,
    output logic [PTR_W-1:0] alloc_pos,
    input  logic [IQ_DEPTH-1:0] finish,
    input  logic             flush,
    output logic [IQ_DEPTH-1:0] validbit,
    output logic [IQ_DEPTH-1:0] finished,
    output logic             commit0_valid,
    output logic [PTR_W-1:0] commit0_pos,
    output logic             commit1_valid,
    output logic [PTR_W-1:0] commit1_pos,
    output logic             commit_mem,
    output logic             halted
`ifdef IQ_COMMIT_STATS_EN
    ,
    output logic [31:0]      stat_retired,
    output logic [31:0]      stat_full_stalls
`endif
);

    commit_state_e state_q, state_d;
    iq_ptr_t       head_q, head_d, tail_q, tail_d, head1;
    logic [CNT_W-1:0] count_q, count_d;
    iq_vec_t       validbit_q, validbit_d, finished_q, finished_d;
    iq_vec_t       is_mem_q, is_mem_d, is_halt_q, is_halt_d;
    logic          sel_c0, sel_c1, sel_mem, sel_halt;
    logic          c0, c1, accept, full;
    logic [1:0]    n_commit;

    iq_commit_select u_select (
        .head_i     (head_q),
        .validbit_i (validbit_q),
        .finished_i (finished_q),
        .is_mem_i   (is_mem_q),
        .is_halt_i  (is_halt_q),
        .state_i    (state_q),
        .head1_o    (head1),
        .c0_o       (sel_c0),
        .c1_o       (sel_c1),
        .mem_o      (sel_mem),
        .halt_o     (sel_halt)
    );

    // Commits are suppressed in the flush cycle; occupancy uses the pre-commit count.
    always_comb begin
        full     = (count_q == CNT_W'(IQ_DEPTH));
        c0       = sel_c0 && !flush;
        c1       = sel_c1 && !flush;
        n_commit = {1'b0, c0} + {1'b0, c1};
        alloc_ready = (state_q == ST_RUN) && !full;
        accept   = alloc_valid && alloc_ready && !flush;
    end

    assign alloc_pos     = tail_q;
    assign validbit      = validbit_q;
    assign finished      = finished_q;
    assign commit0_valid = c0;
    assign commit0_pos   = head_q;
    assign commit1_valid = c1;
    assign commit1_pos   = head1;
    assign commit_mem    = sel_mem && !flush;
    assign halted        = (state_q == ST_HALTED);

    // Next-state: flush > retire/finish/alloc; FSM leaves HALTED only via flush.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        validbit_d = validbit_q;
        finished_d = finished_q;
        is_mem_d   = is_mem_q;
        is_halt_d  = is_halt_q;
        if (flush) begin
            state_d    = ST_RUN;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            validbit_d = '0;
            finished_d = '0;
            is_mem_d   = '0;
            is_halt_d  = '0;
        end else begin
            finished_d = finished_q | (finish & validbit_q);
            if (c0) begin
                validbit_d[head_q] = 1'b0;
                finished_d[head_q] = 1'b0;
            end
            if (c1) begin
                validbit_d[head1] = 1'b0;
                finished_d[head1] = 1'b0;
            end
            // Tail never aliases a retiring slot: alloc requires count < depth.
            if (accept) begin
                validbit_d[tail_q] = 1'b1;
                finished_d[tail_q] = 1'b0;
                is_mem_d[tail_q]   = alloc_is_mem;
                is_halt_d[tail_q]  = alloc_is_halt;
                tail_d             = tail_q + PTR_W'(1);
            end
            head_d  = head_q + PTR_W'(n_commit);
            count_d = count_q + CNT_W'(accept) - CNT_W'(n_commit);
            if (sel_halt) begin
                state_d = ST_HALTED;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            validbit_q <= '0;
            finished_q <= '0;
            is_mem_q   <= '0;
            is_halt_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            validbit_q <= validbit_d;
            finished_q <= finished_d;
            is_mem_q   <= is_mem_d;
            is_halt_q  <= is_halt_d;
        end
    end

`ifdef IQ_COMMIT_STATS_EN
    logic [31:0] ret_q, ret_d, stall_q, stall_d;
    logic [32:0] ret_sum;

    // Saturating counters; cleared only by reset.
    always_comb begin
        ret_sum = {1'b0, ret_q} + 33'(n_commit);
        ret_d   = ret_sum[32] ? 32'hFFFF_FFFF : ret_sum[31:0];
        stall_d = stall_q;
        if (alloc_valid && full && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ret_q   <= '0;
            stall_q <= '0;
        end else begin
            ret_q   <= ret_d;
            stall_q <= stall_d;
        end
    end

    assign stat_retired     = ret_q;
    assign stat_full_stalls = stall_q;
`endif

endmodule

// File: tb/tb_iq_commit.sv
// Randomized + directed bench for iq_commit with an in-order queue reference model.
module tb_iq_commit;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       alloc_valid = 1'b0, alloc_is_mem = 1'b0, alloc_is_halt = 1'b0;
    logic       alloc_ready;
    logic [2:0] alloc_pos;
    logic [7:0] finish = '0;
    logic       flush = 1'b0;
    logic [7:0] validbit, finished;
    logic       commit0_valid, commit1_valid, commit_mem, halted;
    logic [2:0] commit0_pos, commit1_pos;

    iq_commit dut (
        .clk           (clk),
        .nrst          (nrst),
        .alloc_valid   (alloc_valid),
        .alloc_is_mem  (alloc_is_mem),
        .alloc_is_halt (alloc_is_halt),
        .alloc_ready   (alloc_ready),
        .alloc_pos     (alloc_pos),
        .finish        (finish),
        .flush         (flush),
        .validbit      (validbit),
        .finished      (finished),
        .commit0_valid (commit0_valid),
        .commit0_pos   (commit0_pos),
        .commit1_valid (commit1_valid),
        .commit1_pos   (commit1_pos),
        .commit_mem    (commit_mem),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] pos; bit mem; bit halt; bit fin; } ent_t;
    typedef struct { int cyc; int n; logic [2:0] p0; logic [2:0] p1; bit mem; } exp_t;

    ent_t       mq[$];
    exp_t       sb[$];
    logic [2:0] m_tail = '0;
    bit         m_halted = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail   = '0;
        m_halted = 1'b0;
    endtask

    // One cycle: drive inputs, check state, push expected commits, advance the model.
    task automatic step(input bit av, input bit am, input bit ah,
                        input logic [7:0] fin, input bit fl);
        logic [7:0] vb, fb;
        int   n;
        bit   exp_ready;
        exp_t e;
        @(negedge clk);
        alloc_valid = av; alloc_is_mem = am; alloc_is_halt = ah;
        finish = fin; flush = fl;
        cyc++;
        #1;
        vb = '0; fb = '0;
        foreach (mq[i]) begin
            vb[mq[i].pos] = 1'b1;
            if (mq[i].fin) fb[mq[i].pos] = 1'b1;
        end
        exp_ready = !m_halted && (mq.size() < 8);
        chk("validbit", 32'(validbit), 32'(vb));
        chk("finished", 32'(finished), 32'(fb));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
        chk("alloc_pos", 32'(alloc_pos), 32'(m_tail));
        n = 0;
        if (!fl && !m_halted && mq.size() > 0 && mq[0].fin) begin
            n = 1;
            if (!mq[0].halt && mq.size() > 1 && mq[1].fin && !(mq[0].mem && mq[1].mem))
                n = 2;
        end
        if (n > 0) begin
            e.cyc = cyc; e.n = n; e.p0 = mq[0].pos;
            e.p1  = (n == 2) ? mq[1].pos : 3'd0;
            e.mem = mq[0].mem || (n == 2 && mq[1].mem);
            sb.push_back(e);
        end
        if (fl) begin
            model_reset();
        end else begin
            for (int k = 0; k < n; k++) begin
                if (mq[0].halt) m_halted = 1'b1;
                void'(mq.pop_front());
            end
            foreach (mq[i]) if (fin[mq[i].pos]) mq[i].fin = 1'b1;
            if (av && exp_ready) begin
                mq.push_back('{pos: m_tail, mem: am, halt: ah, fin: 1'b0});
                m_tail = m_tail + 3'd1;
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 8'h00, 0);
    endtask

    // Commit monitor: pops the scoreboard whenever the DUT retires.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("commit_missing", 32'(cyc), 32'(e.cyc));
            end
            if (commit0_valid || commit1_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL commit_unexpected cycle %0d: got c0=%0b c1=%0b expected none",
                             cyc, commit0_valid, commit1_valid);
                end else begin
                    e = sb.pop_front();
                    chk("commit_cycle", 32'(cyc), 32'(e.cyc));
                    chk("commit0_valid", 32'(commit0_valid), 32'd1);
                    chk("commit0_pos", 32'(commit0_pos), 32'(e.p0));
                    chk("commit1_valid", 32'(commit1_valid), 32'(e.n == 2));
                    if (e.n == 2) chk("commit1_pos", 32'(commit1_pos), 32'(e.p1));
                    chk("commit_mem", 32'(commit_mem), 32'(e.mem));
                end
            end else begin
                chk("commit_mem_idle", 32'(commit_mem), 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Three non-mem, all finish together.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h07, 0);
        idle(3);

        // Out-of-order finish.
        step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h02, 0);
        idle(1);
        step(0, 0, 0, 8'h01, 0);
        idle(2);

        // Adjacent memory ops.
        step(0, 0, 0, 8'h00, 1);
        step(1, 1, 0, 8'h00, 0);
        step(1, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h03, 0);
        idle(3);

        // Fill, stall, retire two, wrap tail.
        step(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) step(1, i[0], 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h03, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'hFF, 0);
        idle(6);

        // HALT at head.
        step(0, 0, 0, 8'h00, 1);
        step(1, 0, 1, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h03, 0);
        idle(2);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);
        idle(1);

        // Flush colliding with alloc, finish and a committable head.
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h03, 0);
        step(1, 1, 0, 8'hFF, 1);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0,
                 8'($urandom) & 8'($urandom),
                 $urandom_range(0, 49) == 0);
            if (m_halted && $urandom_range(0, 3) == 0) step(0, 0, 0, 8'h00, 1);
        end

        // Reset mid-operation.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 0);
        @(negedge clk);
        alloc_valid = 1'b0; finish = '0; flush = 1'b0;
        nrst = 1'b0;
        model_reset();
        #1;
        chk("reset_validbit", 32'(validbit), 32'd0);
        chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset_alloc_pos", 32'(alloc_pos), 32'd0);
        chk("reset_commit0", 32'(commit0_valid), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h07, 0);
        idle(4);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
